gf180mcu_osu_sc_9t_bist_ctrl2: RTL
==================================

Name: gf180mcu_osu_sc_9T_bist_ctrl2

Overview:
Built-in self-test sequencer for a 2-input combinational standard cell (NOR2, NAND2, AND2, OR2, XOR2 and similar) instantiated on a test structure.
- Drives all four input vectors into the cell under test (CUT), waits a programmable settle time, then samples the CUT output.
- Compares each sample against a truth table and reports an error count, a per-vector fail mask and pass/fail.
- Sits beside the CUT in the characterisation/test wrapper and is started by the scan/config logic.

Parameters:
TT, 4'b0001, expected Y per vector index v={A,B}; TT[v] is the expected value; default is NOR2.
SETTLE, 2, extra wait cycles after a vector is applied before sampling; legal range 0..15.
LOOPS, 1, number of full 4-vector passes per run; must be >= 1.
CNTW, 8, width of the error counter.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RN  input  1  asynchronous active-low reset.
START  input  1  run request; sampled only in IDLE.
A_O  output  1  CUT input A (registered).
B_O  output  1  CUT input B (registered).
Y_I  input  1  CUT output.
BUSY  output  1  high while a run is in progress.
DONE  output  1  single-cycle pulse at the end of a run.
PASS  output  1  result of the last run; 1 when ERR_CNT==0.
ERR_CNT  output  CNTW  mismatch count of the last/current run; saturating.
FAIL_VEC  output  4  sticky per-vector mismatch mask; bit v set if vector v ever mismatched.

Behaviour:
- One clock domain, CLK. RN is asynchronous, active low.
- Reset (RN=0) forces immediately, regardless of state, including mid-run:
  - state=IDLE;
  - A_O=B_O=BUSY=DONE=PASS=0;
  - ERR_CNT=0, FAIL_VEC=0;
  - internal vector, settle and loop counters = 0.
  After release, nothing happens until START.
- States: IDLE, RUN.
- IDLE:
  - A_O=B_O=0, BUSY=0.
  - On an edge with START=1: state<=RUN, BUSY<=1, vec<=0, loop<=0, cnt<=SETTLE, ERR_CNT<=0, FAIL_VEC<=0, PASS<=0.
- RUN:
  - {A_O,B_O} = vec at all times.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0 (sample edge):
    - Compare Y_I with TT[vec].
    - On mismatch: ERR_CNT<=ERR_CNT+1, saturating at 2^CNTW-1; FAIL_VEC[vec]<=1.
    - Then vec<=vec+1 (wraps 3->0), cnt<=SETTLE.
    - On the wrap, loop<=loop+1.
- Each vector occupies exactly SETTLE+1 cycles. SETTLE=0 samples one cycle after the vector is applied.
- Final sample edge (vec==3, loop==LOOPS-1):
  - state<=IDLE, BUSY<=0, DONE<=1;
  - PASS<=(updated ERR_CNT==0), including the mismatch on this edge;
  - A_O,B_O<=0.
- DONE clears on the next edge.
- START-edge-to-DONE latency: 4*LOOPS*(SETTLE+1) edges.
- START while BUSY=1 is ignored; no restart and no timing change.
- START=1 in the DONE cycle (state already IDLE) starts a new run on that edge. DONE still completes its one-cycle pulse, and results clear per IDLE rules.
- ERR_CNT and FAIL_VEC update live during RUN and hold after DONE until the next START or reset.

Optional Feature:
Macro BIST_YSYNC_EN.
- Defined:
  - Y_I passes through a 2-flop synchroniser (both flops reset to 0 by RN) before comparison.
  - The settle reload becomes SETTLE+2, so each vector takes SETTLE+3 cycles.
  - Latency becomes 4*LOOPS*(SETTLE+3).
- Undefined: Y_I is compared directly; no extra flops.

Test Plan:
1. Correct NOR2 model, defaults, START pulse at edge 0:
   - {A_O,B_O} = 00,01,10,11, 3 cycles each;
   - DONE at edge 12, PASS=1, ERR_CNT=0, FAIL_VEC=0000.
2. Y_I stuck at 1, defaults:
   - ERR_CNT=3, FAIL_VEC=4'b1110, PASS=0, DONE at edge 12.
3. LOOPS=3, fault only on vector 2 (A=1,B=0 gives Y=1):
   - ERR_CNT=3, FAIL_VEC=4'b0100, PASS=0, DONE at edge 36.
4. CNTW=2, LOOPS=2, Y_I = inverted NOR2:
   - 8 mismatches; ERR_CNT saturates at 3; FAIL_VEC=1111, PASS=0.
5. START re-pulsed at edge 4 (ignored, DONE still at edge 12). Second run: RN=0 at edge 5:
   - all outputs 0 immediately;
   - after release no activity until START; a fresh run then completes normally.
6. BIST_YSYNC_EN defined, correct NOR2 model, defaults:
   - DONE at edge 20, PASS=1, ERR_CNT=0.

Source files
------------

// File: rtl/gf180mcu_osu_sc_9t_bist_ctrl2.sv
// BIST sequencer for a 2-input combinational standard cell under test (CUT).
// Applies the four input vectors {A,B} = 0..3, waits a programmable settle time,
// samples the CUT output and compares it against a truth table. Reports a
// saturating error count, a sticky per-vector fail mask and a pass flag.
//
// Optional feature: define BIST_YSYNC_EN to pass Y_I through a 2-flop
// synchroniser before comparison. The settle reload then grows by 2 cycles.
//
// Ports:
//   CLK      - clock, all state on the rising edge
//   RN       - asynchronous active-low reset
//   START    - run request, sampled only while idle
//   A_O, B_O - registered CUT inputs
//   Y_I      - CUT output
//   BUSY     - high while a run is in progress
//   DONE     - one-cycle pulse at the end of a run
//   PASS     - result of the last run (ERR_CNT == 0)
//   ERR_CNT  - saturating mismatch count of the last/current run
//   FAIL_VEC - sticky mask, bit v set if vector v mismatched
module gf180mcu_osu_sc_9t_bist_ctrl2 #(
  parameter logic [3:0]  TT     = 4'b0001,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned LOOPS  = 1,
  parameter int unsigned CNTW   = 8
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            START,
  output logic            A_O,
  output logic            B_O,
  input  logic            Y_I,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [CNTW-1:0] ERR_CNT,
  output logic [3:0]      FAIL_VEC
);

  localparam int unsigned LoopW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
`ifdef BIST_YSYNC_EN
  localparam int unsigned Reload = SETTLE + 2;
`else
  localparam int unsigned Reload = SETTLE;
`endif
  localparam logic [4:0]       ReloadVal = 5'(Reload);
  localparam logic [LoopW-1:0] LastLoop  = LoopW'(LOOPS - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q;
  logic [1:0]       vec_q;
  logic [4:0]       cnt_q;
  logic [LoopW-1:0] loop_q;
  logic             a_q, b_q;
  logic             busy_q, done_q, pass_q;
  logic [CNTW-1:0]  err_q;
  logic [3:0]       fail_q;

  // Value of Y used for comparison.
  logic y_cmp;

`ifdef BIST_YSYNC_EN
  logic y_meta_q, y_sync_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      y_meta_q <= 1'b0;
      y_sync_q <= 1'b0;
    end else begin
      y_meta_q <= Y_I;
      y_sync_q <= y_meta_q;
    end
  end

  assign y_cmp = y_sync_q;
`else
  assign y_cmp = Y_I;
`endif

  logic            mismatch;
  logic            last_sample;
  logic [1:0]      vec_nxt;
  logic [CNTW-1:0] err_nxt;

  always_comb begin
    mismatch    = (y_cmp != TT[vec_q]);
    last_sample = (vec_q == 2'd3) && (loop_q == LastLoop);
    vec_nxt     = vec_q + 2'd1;
    err_nxt     = err_q;
    // Saturate rather than wrap so a long run cannot report a false low count.
    if (mismatch && (err_q != {CNTW{1'b1}})) begin
      err_nxt = err_q + CNTW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= StIdle;
      vec_q   <= 2'd0;
      cnt_q   <= 5'd0;
      loop_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          busy_q <= 1'b0;
          if (START) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            vec_q   <= 2'd0;
            loop_q  <= '0;
            cnt_q   <= ReloadVal;
            err_q   <= '0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
          end
        end
        StRun: begin
          if (cnt_q != 5'd0) begin
            cnt_q <= cnt_q - 5'd1;
          end else begin
            // Sample edge: score this vector, then step to the next one.
            err_q <= err_nxt;
            if (mismatch) begin
              fail_q[vec_q] <= 1'b1;
            end
            cnt_q <= ReloadVal;
            vec_q <= vec_nxt;
            a_q   <= vec_nxt[1];
            b_q   <= vec_nxt[0];
            if (vec_q == 2'd3) begin
              loop_q <= loop_q + LoopW'(1);
            end
            if (last_sample) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_nxt == '0);
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              loop_q  <= '0;
            end
          end
        end
      endcase
    end
  end

  assign A_O      = a_q;
  assign B_O      = b_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fail_q;

endmodule
